// File: rtl/mmc_irq_pkg.sv
// Shared encodings for the MMC3-family IRQ counter: register selects,
// save-state selects and the save-state flags word layout.
package mmc_irq_pkg;

  typedef enum logic [1:0] {
    SEL_LATCH  = 2'd0,
    SEL_RELOAD = 2'd1,
    SEL_DIS    = 2'd2,
    SEL_EN     = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    SS_CTR   = 2'd0,
    SS_LATCH = 2'd1,
    SS_FLAGS = 2'd2,
    SS_RSVD  = 2'd3
  } ss_sel_e;

  localparam int FLAG_RLD  = 0;
  localparam int FLAG_PEND = 1;
  localparam int FLAG_EN   = 2;

endpackage

// File: rtl/mmc_a12_filt.sv
// PPU A12 synchroniser and low-time filter. A rising A12 produces a single
// tick only after FILT_LEN consecutive low samples.
module mmc_a12_filt #(
  parameter int FILT_LEN = 4
) (
  input  logic m2,
  input  logic map_rst,
  input  logic ppu_a12,
  output logic tick
);

  logic                a12_s;
  logic [FILT_LEN-1:0] hist;
  logic [FILT_LEN-1:0] hist_nxt;

  generate
    if (FILT_LEN == 1) begin : g_hist_one
      assign hist_nxt = a12_s;
    end else begin : g_hist_multi
      assign hist_nxt = {hist[FILT_LEN-2:0], a12_s};
    end
  endgenerate

  always_ff @(negedge m2 or posedge map_rst) begin
    if (map_rst) begin
      a12_s <= 1'b0;
      hist  <= '0;
    end else begin
      a12_s <= ppu_a12;
      hist  <= hist_nxt;
    end
  end

  // hist holds the previous FILT_LEN samples, so a held-high A12 ticks once
  assign tick = a12_s & (hist == '0);

endmodule

// File: rtl/mmc_irq_scanline.sv
// Scanline / M2-cycle IRQ counter for MMC3-family mappers. Defining
// MMC_IRQ_SS_EN adds the save-state write/readback port (ss_*).
module mmc_irq_scanline
  import mmc_irq_pkg::*;
#(
  parameter int CTR_W    = 8,
  parameter int FILT_LEN = 4
) (
  input  logic             m2,
  input  logic             map_rst,
  input  logic             ppu_a12,
  input  logic             reg_we,
  input  logic [1:0]       reg_sel,
  input  logic [CTR_W-1:0] reg_dat,
  input  logic             cfg_mmc3a,
  input  logic             cfg_cyc_mode,
  output logic             irq,
  output logic [CTR_W-1:0] irq_ctr
`ifdef MMC_IRQ_SS_EN
  ,
  input  logic             ss_we,
  input  logic [1:0]       ss_sel,
  input  logic [CTR_W-1:0] ss_wdat,
  output logic [CTR_W-1:0] ss_rdat
`endif
);

  logic [CTR_W-1:0] ctr, ctr_nxt;
  logic [CTR_W-1:0] latch, latch_nxt;
  logic             rld_req, rld_nxt;
  logic             irq_en, en_nxt;
  logic             irq_pend, pend_nxt;
  logic             a12_tick, tick;
  logic             reload, reload_ctr, fire;

  mmc_a12_filt #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .m2      (m2),
    .map_rst (map_rst),
    .ppu_a12 (ppu_a12),
    .tick    (a12_tick)
  );

  // The filter keeps shifting in cycle mode; its tick is simply ignored.
  assign tick   = cfg_cyc_mode | a12_tick;
  assign reload = rld_req | (~cfg_mmc3a & (ctr == '0));
  // An old-style zero count still reloads rather than wrapping; it just
  // cannot raise the IRQ through that reload.
  assign reload_ctr = rld_req | (ctr == '0);
  assign fire = tick & irq_en & (reload ? (latch == '0) : (ctr == CTR_W'(1)));

  always_comb begin
    ctr_nxt   = ctr;
    latch_nxt = latch;
    rld_nxt   = rld_req;
    en_nxt    = irq_en;
    pend_nxt  = irq_pend | fire;

    if (tick) begin
      ctr_nxt = reload_ctr ? latch : ctr - CTR_W'(1);
      rld_nxt = 1'b0;
    end

    // Writes are applied after the tick so they win on same-cycle collisions.
    if (reg_we) begin
      case (reg_sel)
        SEL_LATCH:  latch_nxt = reg_dat;
        SEL_RELOAD: rld_nxt   = 1'b1;
        SEL_DIS: begin
          en_nxt   = 1'b0;
          pend_nxt = 1'b0;
        end
        SEL_EN:     en_nxt    = 1'b1;
        default: ;
      endcase
    end

`ifdef MMC_IRQ_SS_EN
    if (ss_we) begin
      ctr_nxt   = ctr;
      latch_nxt = latch;
      rld_nxt   = rld_req;
      en_nxt    = irq_en;
      pend_nxt  = irq_pend;
      case (ss_sel)
        SS_CTR:   ctr_nxt   = ss_wdat;
        SS_LATCH: latch_nxt = ss_wdat;
        SS_FLAGS: begin
          rld_nxt  = ss_wdat[FLAG_RLD];
          pend_nxt = ss_wdat[FLAG_PEND];
          en_nxt   = ss_wdat[FLAG_EN];
        end
        default: ;
      endcase
    end
`endif
  end

  always_ff @(negedge m2 or posedge map_rst) begin
    if (map_rst) begin
      ctr      <= '0;
      latch    <= '0;
      rld_req  <= 1'b0;
      irq_en   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      ctr      <= ctr_nxt;
      latch    <= latch_nxt;
      rld_req  <= rld_nxt;
      irq_en   <= en_nxt;
      irq_pend <= pend_nxt;
    end
  end

  assign irq     = irq_pend;
  assign irq_ctr = ctr;

`ifdef MMC_IRQ_SS_EN
  always_comb begin
    ss_rdat = '0;
    case (ss_sel)
      SS_CTR:   ss_rdat = ctr;
      SS_LATCH: ss_rdat = latch;
      SS_FLAGS: begin
        ss_rdat[FLAG_RLD]  = rld_req;
        ss_rdat[FLAG_PEND] = irq_pend;
        ss_rdat[FLAG_EN]   = irq_en;
      end
      default: ;
    endcase
  end
`endif

endmodule
